// File: rtl/io_port_bank_if.sv
// CPU-side I/O bus seen by a bank of Z80 port registers.
// The master drives address, data and strobes. The bank returns read data and a drive-enable.
interface io_port_bank_if;
    logic [15:0] bus_a;
    logic [7:0]  bus_d;
    logic        bus_ioreq;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  d_out;
    logic        d_out_active;

    modport master (
        output bus_a, bus_d, bus_ioreq, bus_rd, bus_wr,
        input  d_out, d_out_active
    );

    modport slave (
        input  bus_a, bus_d, bus_ioreq, bus_rd, bus_wr,
        output d_out, d_out_active
    );
endinterface

// File: rtl/io_port_bank.sv
// Generic bank of Z80 I/O port registers: mask decode, one-shot writes, optional lock, registered reads.
// Define PORT_READBACK_EN to make readable ports return their own latched value instead of rd_src.
module io_port_bank #(
    parameter int unsigned          NPORTS     = 4,
    parameter logic [NPORTS*16-1:0] ADDR_MATCH = 64'h1FFD_DFFD_7FFD_00FE,
    parameter logic [NPORTS*16-1:0] ADDR_MASK  = 64'hF002_F002_8002_0001,
    parameter logic [NPORTS*8-1:0]  RST_VAL    = '0,
    parameter logic [NPORTS-1:0]    RD_EN      = '0,
    parameter logic [NPORTS-1:0]    LOCKABLE   = '0,
    parameter int unsigned          LOCK_IDX   = 0,
    parameter int unsigned          LOCK_BIT   = 5
) (
    input  logic                 clk28,
    input  logic                 rst,
    io_port_bank_if.slave        bus,
    input  logic [NPORTS-1:0]    port_en,
    input  logic                 lock_ovr,
    input  logic [NPORTS*8-1:0]  rd_src,
    output logic [NPORTS*8-1:0]  port_q,
    output logic [NPORTS-1:0]    wr_stb,
    output logic                 locked
);

    logic [NPORTS-1:0][7:0] q_r;
    logic [NPORTS-1:0][7:0] src;
    logic [NPORTS-1:0]      hit;
    logic [NPORTS-1:0]      rd_hit;
    logic [NPORTS-1:0]      wr_do;
    logic [7:0]             rd_data;
    logic [7:0]             d_out_r;
    logic                   d_out_active_r;
    logic                   wr_seen;
    logic                   rst_q;
    logic                   wr_accept;

    assign src    = rd_src;
    assign port_q = q_r;
    assign locked = q_r[LOCK_IDX][LOCK_BIT];

    assign bus.d_out        = d_out_r;
    assign bus.d_out_active = d_out_active_r;

    // rst_q masks the first cycle after reset so a write straddling reset is never taken.
    assign wr_accept = bus.bus_ioreq & bus.bus_wr & ~wr_seen & ~rst_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        hit   = '0;
        rd_hit = '0;
        wr_do = '0;
        for (int i = 0; i < NPORTS; i++) begin
            hit[i]    = bus.bus_ioreq & port_en[i] &
                        (((bus.bus_a ^ ADDR_MATCH[i*16 +: 16]) & ADDR_MASK[i*16 +: 16]) == 16'h0000);
            rd_hit[i] = hit[i] & RD_EN[i] & bus.bus_rd;
            wr_do[i]  = wr_accept & hit[i] & ~(LOCKABLE[i] & locked & ~lock_ovr);
        end
    end

    // Walk from the top so the lowest-index hitting port wins.
    always_comb begin
        rd_data = 8'hFF;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (rd_hit[i]) begin
`ifdef PORT_READBACK_EN
                rd_data = q_r[i];
`else
                rd_data = src[i];
`endif
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk28) begin
        rst_q <= rst;
        if (rst) begin
            q_r            <= RST_VAL;
            wr_stb         <= '0;
            wr_seen        <= 1'b0;
            d_out_r        <= 8'hFF;
            d_out_active_r <= 1'b0;
        end else begin
            if (!bus.bus_wr)
                wr_seen <= 1'b0;
            else if (bus.bus_ioreq)
                wr_seen <= 1'b1;

            wr_stb <= wr_do;
            for (int i = 0; i < NPORTS; i++) begin
                if (wr_do[i])
                    q_r[i] <= bus.bus_d;
            end

            d_out_r        <= rd_data;
            d_out_active_r <= |rd_hit;
        end
    end

endmodule
